// File: rtl/idu_pkg.sv
// rtl/idu_pkg.sv - shared types, opcodes and immediate helper for the idu_stage decode slice
package idu_pkg;

  localparam logic [6:0] OPC_LUI     = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
  localparam logic [6:0] OPC_JAL     = 7'b1101111;
  localparam logic [6:0] OPC_JALR    = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
  localparam logic [6:0] OPC_LOAD    = 7'b0000011;
  localparam logic [6:0] OPC_STORE   = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
  localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
  localparam logic [6:0] OPC_OP      = 7'b0110011;
  localparam logic [6:0] OPC_OP32    = 7'b0111011;
  localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;

  localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
  localparam logic [31:0] INST_MRET   = 32'h3020_0073;

  typedef enum logic [4:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA,
    ALU_OR, ALU_AND, ALU_LUI, ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU,
    ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU
  } alu_op_t;

  typedef enum logic [2:0] {
    IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_SHAMT
  } imm_fmt_t;

  // imm is always carried at 64 bits; the stage keeps the low XLEN bits.
  typedef struct packed {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [63:0] imm;
    alu_op_t     alu_op;
    logic        src1_pc;
    logic        src2_imm;
    logic        word;
    logic        rf_we;
    logic        mem_re;
    logic        mem_we;
    logic [1:0]  mem_size;
    logic        mem_unsigned;
    logic        br;
    logic        jal;
    logic        jalr;
    logic [2:0]  br_cond;
    logic        ebreak;
    logic        ecall;
    logic        mret;
    logic        csr;
    logic        illegal;
  } idu_bundle_t;

  function automatic logic [63:0] imm_gen(input logic [31:0] inst, input imm_fmt_t fmt);
    case (fmt)
      IMM_I:     return {{52{inst[31]}}, inst[31:20]};
      IMM_S:     return {{52{inst[31]}}, inst[31:25], inst[11:7]};
      IMM_B:     return {{51{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      IMM_U:     return {{32{inst[31]}}, inst[31:12], 12'b0};
      IMM_J:     return {{43{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      IMM_SHAMT: return {58'b0, inst[25:20]};
      default:   return 64'b0;
    endcase
  endfunction

endpackage

// File: rtl/idu_decode_comb.sv
// rtl/idu_decode_comb.sv - combinational RV32/RV64 instruction decoder; IDU_M_EXT_EN adds the M extension
module idu_decode_comb
  import idu_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [31:0] inst,
  output idu_bundle_t bundle
);

`ifdef IDU_M_EXT_EN
  localparam bit M_EXT = 1'b1;
`else
  localparam bit M_EXT = 1'b0;
`endif
  localparam bit RV64 = (XLEN == 64);

  logic [6:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;
  imm_fmt_t   fmt;
  logic       ill;
  idu_bundle_t b;

  assign opc = inst[6:0];
  assign f3  = inst[14:12];
  assign f7  = inst[31:25];

  always_comb begin
    b   = '0;
    fmt = IMM_NONE;
    ill = 1'b0;
    case (opc)
      OPC_LUI: begin
        b.rd = inst[11:7]; b.rf_we = 1'b1; b.src2_imm = 1'b1; b.alu_op = ALU_LUI; fmt = IMM_U;
      end
      OPC_AUIPC: begin
        b.rd = inst[11:7]; b.rf_we = 1'b1; b.src1_pc = 1'b1; b.src2_imm = 1'b1; fmt = IMM_U;
      end
      OPC_JAL: begin
        b.rd = inst[11:7]; b.rf_we = 1'b1; b.jal = 1'b1;
        b.src1_pc = 1'b1; b.src2_imm = 1'b1; fmt = IMM_J;
      end
      OPC_JALR: begin
        b.rd = inst[11:7]; b.rs1 = inst[19:15]; b.rf_we = 1'b1; b.jalr = 1'b1;
        b.src2_imm = 1'b1; fmt = IMM_I; ill = (f3 != 3'b000);
      end
      OPC_BRANCH: begin
        b.rs1 = inst[19:15]; b.rs2 = inst[24:20]; b.br = 1'b1; b.br_cond = f3;
        b.src1_pc = 1'b1; b.src2_imm = 1'b1; fmt = IMM_B; ill = (f3[2:1] == 2'b01);
      end
      OPC_LOAD: begin
        b.rd = inst[11:7]; b.rs1 = inst[19:15]; b.rf_we = 1'b1; b.mem_re = 1'b1;
        b.mem_size = f3[1:0]; b.mem_unsigned = f3[2]; b.src2_imm = 1'b1; fmt = IMM_I;
        ill = (f3 == 3'b111) | (!RV64 && (f3 == 3'b011 || f3 == 3'b110));
      end
      OPC_STORE: begin
        b.rs1 = inst[19:15]; b.rs2 = inst[24:20]; b.mem_we = 1'b1; b.mem_size = f3[1:0];
        b.src2_imm = 1'b1; fmt = IMM_S;
        ill = f3[2] | (!RV64 && f3 == 3'b011);
      end
      OPC_OPIMM, OPC_OPIMM32: begin
        b.rd = inst[11:7]; b.rs1 = inst[19:15]; b.rf_we = 1'b1; b.src2_imm = 1'b1; fmt = IMM_I;
        // RV64 full-width shifts borrow funct7[0] as shamt[5]; W shifts and RV32 do not.
        case (f3)
          3'b000: b.alu_op = ALU_ADD;
          3'b010: b.alu_op = ALU_SLT;
          3'b011: b.alu_op = ALU_SLTU;
          3'b100: b.alu_op = ALU_XOR;
          3'b110: b.alu_op = ALU_OR;
          3'b111: b.alu_op = ALU_AND;
          3'b001: begin
            b.alu_op = ALU_SLL; fmt = IMM_SHAMT;
            ill = (RV64 && opc == OPC_OPIMM) ? (inst[31:26] != 6'b0) : (f7 != 7'b0);
          end
          default: begin
            fmt = IMM_SHAMT;
            b.alu_op = inst[30] ? ALU_SRA : ALU_SRL;
            ill = (RV64 && opc == OPC_OPIMM) ? ({inst[31], inst[29:26]} != 5'b0)
                                            : ({f7[6], f7[4:0]} != 6'b0);
          end
        endcase
        if (opc == OPC_OPIMM32) begin
          b.word = 1'b1;
          if (!RV64 || (f3 != 3'b000 && f3 != 3'b001 && f3 != 3'b101)) ill = 1'b1;
        end
      end
      OPC_OP, OPC_OP32: begin
        b.rd = inst[11:7]; b.rs1 = inst[19:15]; b.rs2 = inst[24:20]; b.rf_we = 1'b1;
        case ({f7, f3})
          {7'b0000000, 3'b000}: b.alu_op = ALU_ADD;
          {7'b0100000, 3'b000}: b.alu_op = ALU_SUB;
          {7'b0000000, 3'b001}: b.alu_op = ALU_SLL;
          {7'b0000000, 3'b010}: b.alu_op = ALU_SLT;
          {7'b0000000, 3'b011}: b.alu_op = ALU_SLTU;
          {7'b0000000, 3'b100}: b.alu_op = ALU_XOR;
          {7'b0000000, 3'b101}: b.alu_op = ALU_SRL;
          {7'b0100000, 3'b101}: b.alu_op = ALU_SRA;
          {7'b0000000, 3'b110}: b.alu_op = ALU_OR;
          {7'b0000000, 3'b111}: b.alu_op = ALU_AND;
          {7'b0000001, 3'b000}: b.alu_op = ALU_MUL;
          {7'b0000001, 3'b001}: b.alu_op = ALU_MULH;
          {7'b0000001, 3'b010}: b.alu_op = ALU_MULHSU;
          {7'b0000001, 3'b011}: b.alu_op = ALU_MULHU;
          {7'b0000001, 3'b100}: b.alu_op = ALU_DIV;
          {7'b0000001, 3'b101}: b.alu_op = ALU_DIVU;
          {7'b0000001, 3'b110}: b.alu_op = ALU_REM;
          {7'b0000001, 3'b111}: b.alu_op = ALU_REMU;
          default:              ill = 1'b1;
        endcase
        if (f7 == 7'b0000001 && !M_EXT) ill = 1'b1;
        if (opc == OPC_OP32) begin
          b.word = 1'b1;
          if (!RV64) ill = 1'b1;
          case (b.alu_op)
            ALU_SLT, ALU_SLTU, ALU_XOR, ALU_OR, ALU_AND,
            ALU_MULH, ALU_MULHSU, ALU_MULHU: ill = 1'b1;
            default: ;
          endcase
        end
      end
      OPC_SYSTEM: begin
        if (f3 == 3'b000) begin
          case (inst)
            INST_ECALL:  b.ecall  = 1'b1;
            INST_EBREAK: b.ebreak = 1'b1;
            INST_MRET:   b.mret   = 1'b1;
            default:     ill      = 1'b1;
          endcase
        end else begin
          b.rd = inst[11:7]; b.rs1 = inst[19:15]; b.rf_we = 1'b1; b.csr = 1'b1;
          fmt = IMM_I; ill = (f3 == 3'b100);
        end
      end
      default: ill = 1'b1;
    endcase
    b.imm     = imm_gen(inst, fmt);
    b.illegal = ill;
    if (ill) begin
      b.rf_we  = 1'b0;
      b.mem_re = 1'b0;
      b.mem_we = 1'b0;
    end
    if (b.rd == 5'd0) b.rf_we = 1'b0;
  end

  assign bundle = b;

endmodule

// File: rtl/idu_stage.sv
// rtl/idu_stage.sv - registered decode stage with skid buffer, flush and ebreak halt sequencing
module idu_stage
  import idu_pkg::*;
#(
  parameter int XLEN            = 64,
  parameter int HALT_ON_ILLEGAL = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic [XLEN-1:0] out_imm,
  output logic [4:0]      out_alu_op,
  output logic            out_src1_pc,
  output logic            out_src2_imm,
  output logic            out_word,
  output logic            out_rf_we,
  output logic            out_mem_re,
  output logic            out_mem_we,
  output logic [1:0]      out_mem_size,
  output logic            out_mem_unsigned,
  output logic            out_br,
  output logic            out_jal,
  output logic            out_jalr,
  output logic [2:0]      out_br_cond,
  output logic            out_ebreak,
  output logic            out_ecall,
  output logic            out_mret,
  output logic            out_csr,
  output logic            out_illegal,
  output logic            halted
);

  localparam logic [1:0] ST_RUN       = 2'd0;
  localparam logic [1:0] ST_HALT_PEND = 2'd1;
  localparam logic [1:0] ST_HALTED    = 2'd2;

  logic [1:0]      state;
  idu_bundle_t     dec, out_q, skid_q;
  logic [XLEN-1:0] out_pc_q, skid_pc_q;
  logic            out_valid_q, skid_valid;
  logic            accept, drain, out_free, halt_trig;

  idu_decode_comb #(.XLEN(XLEN)) u_decode (
    .inst   (in_inst),
    .bundle (dec)
  );

  assign in_ready  = (state == ST_RUN) & ~skid_valid & ~flush;
  assign accept    = in_valid & in_ready;
  assign drain     = out_valid_q & out_ready;
  assign out_free  = ~out_valid_q | out_ready;
  assign halt_trig = dec.ebreak | ((HALT_ON_ILLEGAL != 0) & dec.illegal);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      skid_valid  <= 1'b0;
      out_q       <= '0;
      skid_q      <= '0;
      out_pc_q    <= '0;
      skid_pc_q   <= '0;
    end else if (flush) begin
      out_valid_q <= 1'b0;
      skid_valid  <= 1'b0;
    end else if (out_free) begin
      // accept is never high while the skid entry is occupied, so these branches are exclusive
      if (skid_valid) begin
        out_q       <= skid_q;
        out_pc_q    <= skid_pc_q;
        out_valid_q <= 1'b1;
        skid_valid  <= 1'b0;
      end else begin
        out_valid_q <= accept;
        if (accept) begin
          out_q    <= dec;
          out_pc_q <= in_pc;
        end
      end
    end else if (accept) begin
      skid_q     <= dec;
      skid_pc_q  <= in_pc;
      skid_valid <= 1'b1;
    end
  end

  // While pending, nothing younger enters, so the last bundle to drain is the halting one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_RUN;
    end else begin
      case (state)
        ST_RUN:       if (accept && halt_trig) state <= ST_HALT_PEND;
        ST_HALT_PEND: if (flush) state <= ST_RUN;
                      else if (drain && !skid_valid) state <= ST_HALTED;
        ST_HALTED:    state <= ST_HALTED;
        default:      state <= ST_RUN;
      endcase
    end
  end

  assign out_valid        = out_valid_q;
  assign out_pc           = out_pc_q;
  assign out_rs1          = out_q.rs1;
  assign out_rs2          = out_q.rs2;
  assign out_rd           = out_q.rd;
  assign out_imm          = out_q.imm[XLEN-1:0];
  assign out_alu_op       = out_q.alu_op;
  assign out_src1_pc      = out_q.src1_pc;
  assign out_src2_imm     = out_q.src2_imm;
  assign out_word         = out_q.word;
  assign out_rf_we        = out_q.rf_we;
  assign out_mem_re       = out_q.mem_re;
  assign out_mem_we       = out_q.mem_we;
  assign out_mem_size     = out_q.mem_size;
  assign out_mem_unsigned = out_q.mem_unsigned;
  assign out_br           = out_q.br;
  assign out_jal          = out_q.jal;
  assign out_jalr         = out_q.jalr;
  assign out_br_cond      = out_q.br_cond;
  assign out_ebreak       = out_q.ebreak;
  assign out_ecall        = out_q.ecall;
  assign out_mret         = out_q.mret;
  assign out_csr          = out_q.csr;
  assign out_illegal      = out_q.illegal;
  assign halted           = (state == ST_HALTED);

endmodule

// File: tb/tb_idu_stage.sv
// tb/tb_idu_stage.sv - directed bench for idu_stage (RV64 instance plus an RV32 halt-on-illegal instance)
module tb_idu_stage;

  logic clk, rst_n;
  int   nvec = 0;
  int   nerr = 0;

  logic        flush, in_valid, out_ready;
  logic [31:0] in_inst;
  logic [63:0] in_pc;
  logic        in_ready, out_valid, out_src1_pc, out_src2_imm, out_word, out_rf_we;
  logic        out_mem_re, out_mem_we, out_mem_unsigned, out_br, out_jal, out_jalr;
  logic        out_ebreak, out_ecall, out_mret, out_csr, out_illegal, halted;
  logic [63:0] out_pc, out_imm;
  logic [4:0]  out_rs1, out_rs2, out_rd, out_alu_op;
  logic [1:0]  out_mem_size;
  logic [2:0]  out_br_cond;

  logic        r_flush, r_in_valid, r_out_ready;
  logic [31:0] r_in_inst, r_in_pc;
  logic        r_in_ready, r_out_valid, r_src1_pc, r_src2_imm, r_word, r_rf_we;
  logic        r_mem_re, r_mem_we, r_mem_unsigned, r_br, r_jal, r_jalr;
  logic        r_ebreak, r_ecall, r_mret, r_csr, r_illegal, r_halted;
  logic [31:0] r_out_pc, r_imm;
  logic [4:0]  r_rs1, r_rs2, r_rd, r_alu_op;
  logic [1:0]  r_mem_size;
  logic [2:0]  r_br_cond;

  idu_stage #(.XLEN(64), .HALT_ON_ILLEGAL(0)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd), .out_imm(out_imm),
    .out_alu_op(out_alu_op), .out_src1_pc(out_src1_pc), .out_src2_imm(out_src2_imm),
    .out_word(out_word), .out_rf_we(out_rf_we), .out_mem_re(out_mem_re), .out_mem_we(out_mem_we),
    .out_mem_size(out_mem_size), .out_mem_unsigned(out_mem_unsigned), .out_br(out_br),
    .out_jal(out_jal), .out_jalr(out_jalr), .out_br_cond(out_br_cond), .out_ebreak(out_ebreak),
    .out_ecall(out_ecall), .out_mret(out_mret), .out_csr(out_csr), .out_illegal(out_illegal),
    .halted(halted)
  );

  idu_stage #(.XLEN(32), .HALT_ON_ILLEGAL(1)) dut32 (
    .clk(clk), .rst_n(rst_n), .flush(r_flush), .in_valid(r_in_valid), .in_ready(r_in_ready),
    .in_inst(r_in_inst), .in_pc(r_in_pc), .out_valid(r_out_valid), .out_ready(r_out_ready),
    .out_pc(r_out_pc), .out_rs1(r_rs1), .out_rs2(r_rs2), .out_rd(r_rd), .out_imm(r_imm),
    .out_alu_op(r_alu_op), .out_src1_pc(r_src1_pc), .out_src2_imm(r_src2_imm),
    .out_word(r_word), .out_rf_we(r_rf_we), .out_mem_re(r_mem_re), .out_mem_we(r_mem_we),
    .out_mem_size(r_mem_size), .out_mem_unsigned(r_mem_unsigned), .out_br(r_br),
    .out_jal(r_jal), .out_jalr(r_jalr), .out_br_cond(r_br_cond), .out_ebreak(r_ebreak),
    .out_ecall(r_ecall), .out_mret(r_mret), .out_csr(r_csr), .out_illegal(r_illegal),
    .halted(r_halted)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp)
      else begin
        nerr++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] inst, input logic [63:0] pc);
    in_valid = 1'b1; in_inst = inst; in_pc = pc; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_inst = '0; in_pc = '0; out_ready = 1'b0;
    r_flush = 1'b0; r_in_valid = 1'b0; r_in_inst = '0; r_in_pc = '0; r_out_ready = 1'b0;

    // reset
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_halted", halted, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_payload", {out_pc, out_imm, out_rs1, out_rs2, out_rd, out_alu_op, out_rf_we,
                        out_mem_re, out_mem_we, out_illegal, out_ebreak, out_br}, 0);
    chk("rst32_in_ready", r_in_ready, 1);

    // addi x1,x0,-1
    send(32'hFFF00093, 64'h8000_0000);
    chk("addi_valid", out_valid, 1);
    chk("addi_pc", out_pc, 64'h8000_0000);
    chk("addi_rd", out_rd, 1);
    chk("addi_rs1", out_rs1, 0);
    chk("addi_imm", out_imm, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("addi_op", out_alu_op, 0);
    chk("addi_src2", out_src2_imm, 1);
    chk("addi_we", out_rf_we, 1);

    // sraiw x1,x1,1
    send(32'h4010D09B, 64'h8000_0004);
    chk("sraiw_op", out_alu_op, 7);
    chk("sraiw_word", out_word, 1);
    chk("sraiw_imm", out_imm, 1);
    chk("sraiw_ill", out_illegal, 0);

    // lui x5,0x12345
    send(32'h123452B7, 64'h8000_0008);
    chk("lui_op", out_alu_op, 10);
    chk("lui_imm", out_imm, 64'h1234_5000);
    chk("lui_rd", out_rd, 5);

    // beq x1,x2,+8
    send(32'h00208463, 64'h8000_000C);
    chk("beq_flags", {out_br, out_src1_pc, out_src2_imm, out_rf_we, out_br_cond}, 7'b1110_000);
    chk("beq_imm", out_imm, 8);
    chk("beq_rs", {out_rs1, out_rs2}, {5'd1, 5'd2});

    // sw x2,-4(x1)
    send(32'hFE20AE23, 64'h8000_0010);
    chk("sw_mem", {out_mem_we, out_mem_re, out_rf_we, out_mem_size}, 5'b100_10);
    chk("sw_imm", out_imm, 64'hFFFF_FFFF_FFFF_FFFC);

    // lbu x5,0(x1) and ld x1,0(x2)
    send(32'h0000C283, 64'h8000_0014);
    chk("lbu_mem", {out_mem_re, out_mem_unsigned, out_mem_size, out_rd}, {1'b1, 1'b1, 2'd0, 5'd5});
    send(32'h00013083, 64'h8000_0018);
    chk("ld64_mem", {out_mem_re, out_mem_unsigned, out_mem_size, out_illegal}, {1'b1, 1'b0, 2'd3, 1'b0});

    // mul x3,x1,x2
    send(32'h022081B3, 64'h8000_001C);
    chk("mul_rd", out_rd, 3);
`ifdef IDU_M_EXT_EN
    chk("mul_op", out_alu_op, 11);
    chk("mul_we", out_rf_we, 1);
    chk("mul_ill", out_illegal, 0);
`else
    chk("mul_ill", out_illegal, 1);
    chk("mul_we", out_rf_we, 0);
`endif
    step();
    chk("drain_valid", out_valid, 0);

    // backpressure: three back-to-back with out_ready low for two edges
    out_ready = 1'b0;
    in_valid = 1'b1; in_inst = 32'h00100113; in_pc = 64'h100;
    step();
    in_inst = 32'h00200193; in_pc = 64'h104;
    chk("bp_ready_b", in_ready, 1);
    step();
    chk("bp_ready_fall", in_ready, 0);
    in_inst = 32'h00300213; in_pc = 64'h108;
    step();
    chk("bp_hold_pc", out_pc, 64'h100);
    chk("bp_hold_rd", out_rd, 2);
    out_ready = 1'b1;
    step();
    chk("bp_second_pc", out_pc, 64'h104);
    chk("bp_second_imm", out_imm, 2);
    chk("bp_ready_back", in_ready, 1);
    step();
    in_valid = 1'b0;
    chk("bp_third_pc", out_pc, 64'h108);
    chk("bp_third_rd", out_rd, 4);
    chk("bp_third_valid", out_valid, 1);
    step();
    chk("bp_empty", out_valid, 0);

    // flush with output and skid full, flush wins over out_ready
    out_ready = 1'b0;
    in_valid = 1'b1; in_inst = 32'h00100113; in_pc = 64'h180;
    step();
    in_inst = 32'h00200193; in_pc = 64'h184;
    step();
    in_valid = 1'b0; flush = 1'b1; out_ready = 1'b1;
    #1;
    chk("fl_in_ready", in_ready, 0);
    step();
    flush = 1'b0;
    #1;
    chk("fl_out_valid", out_valid, 0);
    chk("fl_in_ready_after", in_ready, 1);

    // ebreak halt sequence
    out_ready = 1'b0;
    in_valid = 1'b1; in_inst = 32'h00100073; in_pc = 64'h200;
    step();
    in_inst = 32'h00500093; in_pc = 64'h204;
    chk("eb_out", {out_valid, out_ebreak, out_rf_we}, 3'b110);
    chk("eb_pend_ready", in_ready, 0);
    chk("eb_pend_halted", halted, 0);
    step();
    chk("eb_still_pc", out_pc, 64'h200);
    chk("eb_still_halted", halted, 0);
    out_ready = 1'b1;
    step();
    chk("eb_halted", halted, 1);
    chk("eb_no_addi", out_valid, 0);
    chk("eb_ready", in_ready, 0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    step();
    chk("eb_flush_halted", halted, 1);
    chk("eb_flush_valid", out_valid, 0);
    chk("eb_flush_ready", in_ready, 0);
    in_valid = 1'b0;

    // RV32 instance: ld is illegal and halts when HALT_ON_ILLEGAL=1
    r_out_ready = 1'b1; r_in_valid = 1'b1; r_in_inst = 32'hFFF00093; r_in_pc = 32'h8000_0000;
    step();
    r_in_inst = 32'h00013083; r_in_pc = 32'h8000_0004;
    chk("r32_addi_imm", r_imm, 64'hFFFF_FFFF);
    chk("r32_addi_ill", r_illegal, 0);
    step();
    r_in_valid = 1'b0;
    chk("r32_ld_ill", {r_out_valid, r_illegal, r_mem_re, r_rf_we}, 4'b1100);
    chk("r32_ld_pc", r_out_pc, 64'h8000_0004);
    chk("r32_pend_ready", r_in_ready, 0);
    chk("r32_pend_halted", r_halted, 0);
    step();
    chk("r32_halted", r_halted, 1);
    chk("r32_empty", r_out_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/idu_stage.md
Name: idu_stage

Overview:
- Registered RISC-V decode stage for the NPC core; successor to the single-cycle combinational control decoder.
- Sits between IFU and EXU and carries one instruction per valid/ready handshake.
- Parametrised for RV32/RV64, with full-throughput skid buffering, flush and an ebreak halt state machine.
- Branch resolution moves downstream: the stage passes funct3 as the branch condition and no longer takes comparator inputs.

Parameters:
- XLEN, 64: datapath width, 32 or 64; sizes PC and immediate.
- HALT_ON_ILLEGAL, 0: when 1, an illegal instruction enters the halt sequence exactly as ebreak does.

Ports:
- clk, input, 1: clock.
- rst_n, input, 1: asynchronous active-low reset.
- flush, input, 1: synchronous kill of all buffered instructions.
- in_valid, input, 1: IFU offers an instruction.
- in_ready, output, 1: stage can accept.
- in_inst, input, 32: instruction word.
- in_pc, input, XLEN: instruction PC.
- out_valid, output, 1: decoded bundle valid.
- out_ready, input, 1: EXU accepts.
- out_pc, output, XLEN: PC of the bundle.
- out_rs1, out_rs2, out_rd, output, 5 each: register indices.
- out_imm, output, XLEN: sign-extended immediate.
- out_alu_op, output, 5: alu_op_t.
- out_src1_pc, output, 1: ALU operand 1 is PC (auipc/jal/branch).
- out_src2_imm, output, 1: ALU operand 2 is the immediate.
- out_word, output, 1: *W operation; result is sign-extended from bit 31.
- out_rf_we, output, 1: rd write; forced 0 when rd==0.
- out_mem_re, out_mem_we, output, 1 each: load / store.
- out_mem_size, output, 2: 0=B, 1=H, 2=W, 3=D.
- out_mem_unsigned, output, 1: lbu/lhu/lwu.
- out_br, out_jal, out_jalr, output, 1 each: control-flow class.
- out_br_cond, output, 3: funct3 of the branch.
- out_ebreak, out_ecall, out_mret, out_csr, output, 1 each: system class.
- out_illegal, output, 1: undecodable instruction.
- halted, output, 1: stage has stopped.

Behaviour:
- Reset (async, rst_n low):
  - out_valid=0, all payload outputs 0, skid buffer empty, state RUN, halted=0.
  - in_ready=1 once rst_n deasserts.
- Handshakes:
  - A transfer occurs when valid&ready are both high on a rising clk edge.
  - Latency is 1 cycle: an instruction accepted at edge N is presented at out_* after edge N.
- Buffering:
  - Storage is one output register plus one skid entry.
  - in_ready = (state==RUN) & ~skid_valid & ~flush.
  - If the input is accepted while out_valid&~out_ready, the decoded bundle goes to the skid entry.
  - When the output drains, the skid entry moves to the output register.
  - Throughput is 1/cycle with no bubbles; order is strictly preserved.
  - out_* must be held stable while out_valid&~out_ready.
- Decode rules:
  - Immediate formats I/S/B/U/J are sign-extended to XLEN.
  - Shift immediates:
    - XLEN=64: shamt is inst[25:20]; inst[31:26] must be 000000 or 010000.
    - XLEN=32: inst[25] must be 0.
  - When XLEN=32, these are illegal: ld, lwu, sd, opcodes 0011011 and 0111011.
  - Any unmatched opcode/funct3/funct7 is illegal.
  - An illegal bundle has out_illegal=1, out_rf_we=0, out_mem_re=0 and out_mem_we=0.
- State machine: RUN, HALT_PEND, HALTED.
  - RUN -> HALT_PEND: an ebreak (or an illegal instruction when HALT_ON_ILLEGAL=1) is accepted at the input.
  - HALT_PEND -> HALTED: that bundle is accepted at the output.
  - HALTED: in_ready=0 and halted=1 until reset.
  - HALT_PEND: in_ready=0, so no younger instruction enters.
- Flush (synchronous, priority over all handshakes):
  - Clears out_valid and skid_valid; nothing is accepted in that cycle.
  - In HALT_PEND, flush returns the state to RUN.
  - In HALTED, flush has no effect.
- Simultaneous events:
  - out drain and in accept in the same cycle: the output register reloads directly; the skid buffer stays empty.
  - flush together with out_ready: the flush wins; the bundle is treated as not delivered.

Optional Feature:
- Macro: IDU_M_EXT_EN.
- Defined: decodes mul/mulh/mulhsu/mulhu/div/divu/rem/remu, plus mulw/divw/divuw/remw/remuw when XLEN=64, onto the matching alu_op_t values.
- Undefined: every funct7=0000001 encoding under opcodes 0110011/0111011 is illegal.

Decomposition:
- Package idu_pkg holds:
  - alu_op_t enum: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, LUI, MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
  - Opcode localparams.
  - The imm_fmt_t enum.
  - A packed idu_bundle_t struct for the decoded payload.
- Sub-module idu_decode_comb:
  - Purely combinational: inst -> idu_bundle_t, parametrised by XLEN.
  - idu_stage instantiates it once and stores its output in the output and skid registers.

Test Plan:
1. Reset: hold rst_n=0 for 3 cycles, then release -> out_valid=0, halted=0, in_ready=1, all payload outputs 0.
2. addi x1,x0,-1 (0xFFF00093) at pc 0x80000000, out_ready=1 -> next cycle: out_valid=1, out_pc=0x80000000, rd=1, rs1=0, imm all-ones, alu_op ADD, src2_imm=1, rf_we=1.
3. Backpressure: three back-to-back instructions with out_ready=0 for 2 cycles -> in_ready falls after the second is accepted; after release, all three emerge in order with no loss or duplication.
4. ebreak (0x00100073) followed by an addi -> ebreak delivered with out_ebreak=1; halted=1 the cycle after the output handshake; addi never accepted; a flush in HALTED changes nothing.
5. XLEN=32: ld x1,0(x2) (0x00013083) -> out_illegal=1, mem_re=0. XLEN=64: sraiw x1,x1,1 (0x4010D09B) -> alu_op SRA, word=1, imm=1.
6. mul x3,x1,x2 (0x022081B3) -> with IDU_M_EXT_EN: alu_op MUL, rd=3, rf_we=1; without it: out_illegal=1, rf_we=0.
